// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux datapath among four requesters.
// A grant is held for a whole multi-beat transaction, with a beat-count watchdog.
module mux4_rr_arbiter #(
  parameter int unsigned MaxBeats = 16,
  parameter int unsigned CntWidth = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] last,
  input  logic       out_ready,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       busy,
  output logic       beat_fire,
  output logic       overrun
);

  localparam int unsigned NumSrc = 4;
  localparam logic [CntWidth-1:0] BeatLimit = CntWidth'(MaxBeats);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]          grant_d;
  logic [1:0]          select_d;
  logic                busy_d, overrun_d;
  logic [1:0]          winner;
  logic                found;

  assign beat_fire = busy & req[select] & out_ready;
  assign cnt_inc   = cnt_q + CntWidth'(1);

  // First requester at or after the priority pointer, wrapping mod 4
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (!found && req[ptr_q + 2'(i)]) begin
        winner = ptr_q + 2'(i);
        found  = 1'b1;
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant;
    select_d  = select;
    busy_d    = busy;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = GRANT;
          grant_d  = 4'b0001 << winner;
          select_d = winner;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        if (beat_fire) cnt_d = cnt_inc;
        // Release on last beat, abandoned request, or watchdog; last beats watchdog
        if (!req[select] || (beat_fire && (last[select] || (cnt_inc == BeatLimit)))) begin
          state_d   = IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          ptr_d     = select + 2'd1;
          overrun_d = beat_fire & ~last[select];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant   <= '0;
      select  <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant   <= grant_d;
      select  <= select_d;
      busy    <= busy_d;
      overrun <= overrun_d;
    end
  end

endmodule
